// File: rtl/overture_exec_sequencer.sv
// OVERTURE multi-cycle instruction sequencer: fetch, class decode, copy I/O stall, condition eval.
// Optional macro OVERTURE_SEQ_ILLEGAL_TRAP_EN turns reserved copy index 7 into a HALT trap.
module overture_exec_sequencer #(
  parameter int    UUID = 0,
  parameter string NAME = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] cond_value,
  input  logic       in_valid,
  output logic       in_ack,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] src_sel,
  output logic [7:0] dst_sel,
  output logic       wr_en,
  output logic       imm_load,
  output logic       alu_en,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       illegal,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXEC    = 2'd1,
    IO_WAIT = 2'd2,
    HALT    = 2'd3
  } state_t;

  state_t     state_r, next_state_s;
  logic [7:0] ir_r;
  logic [2:0] src_idx_s, dst_idx_s;
  logic       need_in_s, need_out_s, io_ok_s, reserved_s;

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    onehot = 8'd1 << idx;
  endfunction

  // Signed compare of reg3 against zero; bit 2 of the code inverts the base test.
  function automatic logic cond_true(input logic [2:0] code, input logic [7:0] v);
    logic z, n;
    z = (v == 8'd0);
    n = v[7];
    case (code)
      3'b000:  cond_true = 1'b0;
      3'b001:  cond_true = z;
      3'b010:  cond_true = n;
      3'b011:  cond_true = n | z;
      3'b100:  cond_true = 1'b1;
      3'b101:  cond_true = ~z;
      3'b110:  cond_true = ~n;
      3'b111:  cond_true = ~n & ~z;
      default: cond_true = 1'b0;
    endcase
  endfunction

  assign src_idx_s  = ir_r[5:3];
  assign dst_idx_s  = ir_r[2:0];
  assign need_in_s  = (src_idx_s == 3'd6);
  assign need_out_s = (dst_idx_s == 3'd6);
  assign reserved_s = (src_idx_s == 3'd7) || (dst_idx_s == 3'd7);
  assign io_ok_s    = (!need_in_s || in_valid) && (!need_out_s || out_ready);
  assign state_o    = state_r;

  // State register and instruction register capture on the fetch handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
      ir_r    <= 8'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == FETCH && run && instr_valid) begin
        ir_r <= instr;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

  // Next-state and strobe decode; rst masks every strobe so no partial write escapes.
  always_comb begin
    next_state_s = state_r;
    instr_ready  = 1'b0;
    in_ack       = 1'b0;
    out_valid    = 1'b0;
    src_sel      = 8'd0;
    dst_sel      = 8'd0;
    wr_en        = 1'b0;
    imm_load     = 1'b0;
    alu_en       = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    illegal      = 1'b0;
    if (rst) begin
      instr_ready  = run;
      next_state_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          instr_ready = run;
          if (run && instr_valid) begin
            next_state_s = EXEC;
          end else begin
            next_state_s = FETCH;
          end
        end
        EXEC: begin
          next_state_s = FETCH;
          case (ir_r[7:6])
            2'b00: begin
              dst_sel  = 8'h01;
              imm_load = 1'b1;
              wr_en    = 1'b1;
              pc_inc   = 1'b1;
            end
            2'b01: begin
              alu_en  = 1'b1;
              dst_sel = 8'h08;
              wr_en   = 1'b1;
              pc_inc  = 1'b1;
            end
            2'b10: begin
              if (reserved_s) begin
`ifdef OVERTURE_SEQ_ILLEGAL_TRAP_EN
                illegal      = 1'b1;
                next_state_s = HALT;
`else
                src_sel = (src_idx_s == 3'd7) ? 8'd0 : onehot(src_idx_s);
                dst_sel = (dst_idx_s == 3'd7) ? 8'd0 : onehot(dst_idx_s);
                pc_inc  = 1'b1;
`endif
              end else begin
                src_sel = onehot(src_idx_s);
                dst_sel = onehot(dst_idx_s);
                if (io_ok_s) begin
                  wr_en     = 1'b1;
                  pc_inc    = 1'b1;
                  in_ack    = need_in_s;
                  out_valid = need_out_s;
                end else begin
                  next_state_s = IO_WAIT;
                end
              end
            end
            2'b11: begin
              if (cond_true(ir_r[2:0], cond_value)) begin
                pc_load = 1'b1;
              end else begin
                pc_inc = 1'b1;
              end
            end
            default: next_state_s = FETCH;
          endcase
        end
        IO_WAIT: begin
          src_sel = onehot(src_idx_s);
          dst_sel = onehot(dst_idx_s);
          if (io_ok_s) begin
            wr_en        = 1'b1;
            pc_inc       = 1'b1;
            in_ack       = need_in_s;
            out_valid    = need_out_s;
            next_state_s = FETCH;
          end else begin
            next_state_s = IO_WAIT;
          end
        end
        HALT: begin
`ifdef OVERTURE_SEQ_ILLEGAL_TRAP_EN
          illegal      = 1'b1;
          next_state_s = HALT;
`else
          next_state_s = FETCH;
`endif
        end
        default: next_state_s = FETCH;
      endcase
    end
  end

endmodule

// File: doc/overture_exec_sequencer.md
Name: overture_exec_sequencer

Overview:
- Multi-cycle instruction sequencer for the OVERTURE core.
- Fetches an 8-bit instruction over a valid/ready handshake and decodes the class field.
- Drives one-hot source and destination selects for the register file and I/O, strobes the ALU and immediate paths, evaluates conditions, and issues PC increment/load.
- Stalls on the input and output handshakes.

Parameters:
- UUID, 0, instance identifier XORed into child UUIDs.
- NAME, "", instance label; no functional effect.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- run  input  1  run enable; fetch is allowed only while high.
- instr  input  8  instruction byte from program memory.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  sequencer accepts instr this cycle.
- cond_value  input  8  reg3 contents, signed two's complement.
- in_valid  input  1  external input byte available.
- in_ack  output  1  input byte consumed (1-cycle pulse).
- out_ready  input  1  external sink can take a byte.
- out_valid  output  1  output byte presented (1-cycle pulse).
- src_sel  output  8  one-hot read select; bit n = register n, bit 6 = input.
- dst_sel  output  8  one-hot write select; bit n = register n, bit 6 = output.
- wr_en  output  1  destination write strobe.
- imm_load  output  1  route immediate (ir[5:0], zero-extended) to the write bus.
- alu_en  output  1  route ALU result (op ir[2:0], operands reg1/reg2) to the write bus.
- pc_inc  output  1  increment PC.
- pc_load  output  1  load PC from reg0.
- illegal  output  1  reserved select index was decoded.
- state_o  output  2  current state, for debug.

Behaviour:
- States: FETCH=0, EXEC=1, IO_WAIT=2, HALT=3.
- Reset: state=FETCH, ir=0, all outputs 0 except instr_ready=run.
- FETCH:
  - instr_ready=run.
  - On instr_valid&&instr_ready: ir<=instr, go to EXEC.
  - Otherwise stay. All strobes are 0.
- EXEC: exactly one cycle. Outputs are combinational from ir and state; ir[7:6] selects the class.
  - 00 immediate: dst_sel=8'b0000_0001, imm_load=1, wr_en=1, pc_inc=1, then FETCH.
  - 01 calculate: alu_en=1, dst_sel=8'b0000_1000, wr_en=1, pc_inc=1, then FETCH.
  - 10 copy: src index s=ir[5:3], destination index d=ir[2:0]; src_sel=1<<s, dst_sel=1<<d.
    - Needs input if s==6; needs output if d==6.
    - All needed sides ready (in_valid / out_ready): wr_en=1, pc_inc=1, in_ack=(s==6), out_valid=(d==6), then FETCH.
    - Otherwise: wr_en=0, no pc_inc, go to IO_WAIT.
  - 11 condition: evaluate cond_value with code ir[2:0]:
    - 000 never; 001 ==0; 010 <0; 011 <=0; 100 always; 101 !=0; 110 >=0; 111 >0.
    - True: pc_load=1. False: pc_inc=1. Then FETCH. src_sel/dst_sel=0, wr_en=0.
- IO_WAIT:
  - src_sel/dst_sel held from ir; wr_en=0.
  - Re-tests readiness every cycle.
  - When all needed sides are ready in the same cycle: wr_en=1, pc_inc=1, in_ack/out_valid as in EXEC, then FETCH.
  - Copy 6->6 requires in_valid&&out_ready in the same cycle. One side alone does not complete.
- Reserved index 7 (s==7 or d==7) in a copy: behaviour is defined under Optional Feature.
- Exclusivity: pc_inc and pc_load are never both 1. Exactly one of them pulses per completed instruction.
- run low:
  - Blocks only the next fetch.
  - An instruction already in EXEC/IO_WAIT completes normally.
- rst mid-operation: rst has priority over all transitions. Next cycle is FETCH with all strobes 0, and no partial write occurs.
- Throughput: 2 cycles per instruction minimum, FETCH+EXEC, with no I/O stall.

Optional Feature:
- Macro: OVERTURE_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - A copy with s==7 or d==7 in EXEC asserts illegal=1 and enters HALT.
  - No wr_en and no pc_inc.
  - HALT holds all strobes 0, instr_ready=0 and illegal=1 until rst.
- Not defined:
  - The index-7 side's one-hot bit is suppressed: src_sel/dst_sel bit 7 is never driven.
  - wr_en=0, pc_inc=1 (no-op), then FETCH.
  - illegal is tied to 0 and HALT is unreachable.

Test Plan:
- Reset, run=1, instr=8'h2A valid -> cycle after handshake: imm_load=1, dst_sel=8'h01, wr_en=1, pc_inc=1; state returns to FETCH.
- instr=8'b10_001_101 (copy reg1->reg5) -> EXEC: src_sel=8'h02, dst_sel=8'h20, wr_en=1, pc_inc=1, in_ack=0, out_valid=0.
- instr=8'b10_110_010 (input->reg2), in_valid=0 for 3 cycles then 1 -> IO_WAIT for 3 cycles with wr_en=0; completion cycle has wr_en=1, in_ack=1, pc_inc=1, dst_sel=8'h04.
- Condition ir=8'b11_000_010 (<0) with cond_value=8'hF0 -> pc_load=1, pc_inc=0. With cond_value=8'h00 -> pc_inc=1, pc_load=0. Code 000 with any value -> pc_inc=1.
- instr=8'b10_110_110 (input->output) with out_ready=1, in_valid toggling 0/1 -> completes only on the in_valid=1 cycle: in_ack=1, out_valid=1 together. Assert rst during IO_WAIT -> next cycle FETCH, no wr_en pulse.
- instr=8'b10_111_000:
  - With OVERTURE_SEQ_ILLEGAL_TRAP_EN: illegal=1, HALT, instr_ready stays 0 despite instr_valid.
  - Without it: src_sel=0, pc_inc=1, illegal=0.
